// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS word decoder.
// Token codes are written MSB (bit 9) first; bit 0 is the earliest bit on the wire.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  localparam logic [4:0]  LOCK_RUN       = 5'd16;
  localparam logic [11:0] SEARCH_TIMEOUT = 12'd4095;
  localparam logic [12:0] LOSS_WDOG      = 13'd8191;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one aligned 10-bit TMDS word into a pixel byte or a control token.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_token
);

  logic [7:0] d;

  // Bit 9 undoes the disparity inversion; bit 8 picks XOR or XNOR chaining.
  always_comb begin
    d       = word[9] ? ~word[7:0] : word[7:0];
    data    = 8'h00;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (word)
      TOK_C00: ctrl = 2'b00;
      TOK_C01: ctrl = 2'b01;
      TOK_C10: ctrl = 2'b10;
      TOK_C11: ctrl = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip word alignment on control-token runs, then registered
// decode of each loaded word into pixel data or control bits with a one-cycle valid strobe.
module tmds_decoder
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       s_rst,
  input  logic       load,
  input  logic [9:0] data_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       valid_out,
  output logic       locked,
  output logic [3:0] offset
);

  state_t      state, state_nx;
  logic [9:0]  prev;
  logic [4:0]  tok_run, tok_run_nx;
  logic [11:0] timeout, timeout_nx;
  logic [12:0] wdog, wdog_nx;
  logic [3:0]  offset_nx;
  logic        emit;

  logic [9:0]  aligned;
  logic [7:0]  dec_data;
  logic [1:0]  dec_ctrl;
  logic        dec_tok;

  // The 20-bit window keeps the older word in the low half, so offset 0 selects prev.
  assign aligned = 10'({data_in, prev} >> offset);

  tmds_word_decode u_dec (
    .word     (aligned),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_token (dec_tok)
  );

  always_comb begin
    state_nx   = state;
    offset_nx  = offset;
    tok_run_nx = tok_run;
    timeout_nx = timeout;
    wdog_nx    = wdog;
    emit       = 1'b0;
    if (load) begin
      case (state)
        ST_SEARCH: begin
          tok_run_nx = dec_tok ? tok_run + 5'd1 : 5'd0;
          timeout_nx = timeout + 12'd1;
          if (tok_run_nx == LOCK_RUN) begin
            state_nx   = ST_LOCKED;
            tok_run_nx = 5'd0;
            timeout_nx = 12'd0;
          end else if (timeout_nx == SEARCH_TIMEOUT) begin
            offset_nx  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            tok_run_nx = 5'd0;
            timeout_nx = 12'd0;
          end
        end
        ST_LOCKED: begin
          emit    = 1'b1;
          wdog_nx = dec_tok ? 13'd0 : wdog + 13'd1;
          if (wdog_nx == LOSS_WDOG) begin
            state_nx = ST_SEARCH;
            wdog_nx  = 13'd0;
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEARCH;
      offset    <= 4'd0;
      prev      <= 10'd0;
      tok_run   <= 5'd0;
      timeout   <= 12'd0;
      wdog      <= 13'd0;
      data_out  <= 8'h00;
      ctrl_out  <= 2'b00;
      de_out    <= 1'b0;
      valid_out <= 1'b0;
      locked    <= 1'b0;
    end else if (s_rst) begin
      state     <= ST_SEARCH;
      offset    <= 4'd0;
      prev      <= 10'd0;
      tok_run   <= 5'd0;
      timeout   <= 12'd0;
      wdog      <= 13'd0;
      data_out  <= 8'h00;
      ctrl_out  <= 2'b00;
      de_out    <= 1'b0;
      valid_out <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      offset    <= offset_nx;
      tok_run   <= tok_run_nx;
      timeout   <= timeout_nx;
      wdog      <= wdog_nx;
      locked    <= (state_nx == ST_LOCKED);
      valid_out <= emit;
      if (load) prev <= data_in;
      // The field not being decoded keeps its previous value.
      if (emit) begin
        de_out <= ~dec_tok;
        if (dec_tok) ctrl_out <= dec_ctrl;
        else         data_out <= dec_data;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a driver steps a behavioural model per load and queues
// expected outputs; an independent monitor pops and compares each cycle.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_rst = 1'b0;
  logic       load = 1'b0;
  logic [9:0] data_in = 10'd0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       valid_out;
  logic       locked;
  logic [3:0] offset;

  tmds_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .s_rst     (s_rst),
    .load      (load),
    .data_in   (data_in),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .valid_out (valid_out),
    .locked    (locked),
    .offset    (offset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sr_seen = 1'b0;
  always @(posedge clk) sr_seen <= s_rst;

  typedef struct { int due; bit de; logic [1:0] ctrl; logic [7:0] data; } oexp_t;
  typedef struct { int due; bit lk; logic [3:0] off; } sexp_t;
  oexp_t oq[$];
  sexp_t sq[$];

  logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // Behavioural reference state
  bit         m_lk;
  int         m_off, m_run, m_tmo, m_wd;
  logic [9:0] m_prev;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 1'b0;

  function automatic bit ref_decode(input logic [9:0] a, output logic [1:0] c, output logic [7:0] b);
    logic [7:0] d;
    bit found;
    found = 1'b0;
    c = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (a == TOK[k]) begin
        found = 1'b1;
        c = 2'(k);
      end
    end
    d = a[9] ? ~a[7:0] : a[7:0];
    b = d ^ {d[6:0], 1'b0};
    if (!a[8]) b = b ^ 8'hFE;
    return found;
  endfunction

  function automatic logic [9:0] tmds_encode(input logic [7:0] dv, input bit inv);
    int n1;
    bit use_xnor;
    logic [8:0] qm;
    n1 = $countones(dv);
    use_xnor = (n1 > 4) || (n1 == 4 && dv[0] == 1'b0);
    qm[0] = dv[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ dv[i]) : (qm[i-1] ^ dv[i]);
    qm[8] = ~use_xnor;
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic m_reset();
    m_lk = 1'b0; m_off = 0; m_run = 0; m_tmo = 0; m_wd = 0; m_prev = 10'd0;
  endtask

  task automatic m_step(input logic [9:0] w, output bit em, output oexp_t e);
    logic [19:0] win;
    logic [9:0]  a;
    logic [1:0]  c;
    logic [7:0]  b;
    bit tk;
    win = {w, m_prev};
    a = 10'(win >> m_off);
    tk = ref_decode(a, c, b);
    em = m_lk;
    e.due = cyc + 1; e.de = !tk; e.ctrl = c; e.data = b;
    if (m_lk) begin
      m_wd = tk ? 0 : m_wd + 1;
      if (m_wd == 8191) begin m_lk = 1'b0; m_wd = 0; end
    end else begin
      m_run = tk ? m_run + 1 : 0;
      m_tmo = m_tmo + 1;
      if (m_run == 16) begin
        m_lk = 1'b1; m_run = 0; m_tmo = 0;
      end else if (m_tmo == 4095) begin
        m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
      end
    end
    m_prev = w;
  endtask

  // ovo/ovs replace the model's expectation with a hand-derived constant one.
  task automatic do_load(input logic [9:0] w,
                         input bit ovo = 1'b0, input bit ode = 1'b0,
                         input logic [1:0] octl = 2'b00, input logic [7:0] odat = 8'h00,
                         input bit ovs = 1'b0, input bit olk = 1'b0, input logic [3:0] ooff = 4'd0);
    bit em;
    oexp_t e;
    sexp_t s;
    @(negedge clk);
    load = 1'b1; s_rst = 1'b0; data_in = w;
    m_step(w, em, e);
    if (ovo) begin e.de = ode; e.ctrl = octl; e.data = odat; end
    if (em || ovo) oq.push_back(e);
    s.due = cyc + 1; s.lk = m_lk; s.off = 4'(m_off);
    if (ovs) begin s.lk = olk; s.off = ooff; end
    sq.push_back(s);
  endtask

  task automatic do_idle();
    @(negedge clk);
    load = 1'b0; s_rst = 1'b0;
  endtask

  task automatic do_srst();
    sexp_t s;
    @(negedge clk);
    load = 1'b1; data_in = TOK[0]; s_rst = 1'b1;
    m_reset();
    s.due = cyc + 1; s.lk = 1'b0; s.off = 4'd0;
    sq.push_back(s);
  endtask

  task automatic do_rst();
    @(negedge clk);
    load = 1'b0; s_rst = 1'b0;
    #2 rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor
  initial begin
    logic       h_de;
    logic [1:0] h_ctl;
    logic [7:0] h_dat;
    oexp_t e;
    sexp_t s;
    h_de = 1'b0; h_ctl = 2'b00; h_dat = 8'h00;
    while (!done) begin
      @(negedge clk or posedge rst);
      #1;
      if (rst) begin
        h_de = 1'b0; h_ctl = 2'b00; h_dat = 8'h00;
        chk("rst_valid_out", 32'(valid_out), 32'(1'b0));
        chk("rst_locked",    32'(locked),    32'(1'b0));
        chk("rst_offset",    32'(offset),    32'(4'd0));
        chk("rst_de_out",    32'(de_out),    32'(1'b0));
        chk("rst_ctrl_out",  32'(ctrl_out),  32'(2'b00));
        chk("rst_data_out",  32'(data_out),  32'(8'h00));
      end else begin
        if (sr_seen) begin h_de = 1'b0; h_ctl = 2'b00; h_dat = 8'h00; end
        while (sq.size() > 0 && sq[0].due < cyc) begin
          chk("state_missed", 32'(cyc), 32'(sq[0].due));
          void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].due == cyc) begin
          s = sq.pop_front();
          chk("locked", 32'(locked), 32'(s.lk));
          chk("offset", 32'(offset), 32'(s.off));
        end
        while (oq.size() > 0 && oq[0].due < cyc) begin
          chk("out_missed", 32'(cyc), 32'(oq[0].due));
          void'(oq.pop_front());
        end
        if (oq.size() > 0 && oq[0].due == cyc) begin
          e = oq.pop_front();
          chk("valid_out", 32'(valid_out), 32'(1'b1));
          chk("de_out", 32'(de_out), 32'(e.de));
          if (e.de) begin
            chk("data_out", 32'(data_out), 32'(e.data));
            h_dat = e.data;
          end else begin
            chk("ctrl_out", 32'(ctrl_out), 32'(e.ctrl));
            h_ctl = e.ctrl;
          end
          h_de = e.de;
        end else begin
          chk("valid_idle", 32'(valid_out), 32'(1'b0));
          chk("hold_de",    32'(de_out),    32'(h_de));
          chk("hold_ctrl",  32'(ctrl_out),  32'(h_ctl));
          chk("hold_data",  32'(data_out),  32'(h_dat));
        end
      end
    end
    chk("pending_out",   32'(oq.size()), 32'(0));
    chk("pending_state", 32'(sq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "time budget expired");
  end

  // Driver
  initial begin
    logic [9:0] t0, rot, w;
    logic [7:0] prev_b;
    bit first, ck, lk;
    logic [3:0] off;
    int r;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Lock on aligned C00 tokens, then data words of both disparity forms.
    for (int i = 0; i < 20; i++)
      do_load(TOK[0], 1'b0, 1'b0, 2'b00, 8'h00, (i == 15 || i == 16), (i == 16), 4'd0);
    do_load(10'b1000000000);
    do_load(10'b0100000000, 1'b1, 1'b1, 2'b00, 8'hFF);
    do_load(TOK[0],         1'b1, 1'b1, 2'b00, 8'h00);

    do_load(TOK[3]);
    do_load(TOK[1], 1'b1, 1'b0, 2'b11);
    do_load(TOK[0], 1'b1, 1'b0, 2'b01);

    repeat (400) begin
      r = $urandom_range(0, 7);
      if (r == 0)     do_idle();
      else if (r < 3) do_load(TOK[$urandom_range(0, 3)]);
      else            do_load(10'($urandom));
    end

    // Encode every byte in both polarities; each decode appears one load later.
    first = 1'b1;
    prev_b = 8'h00;
    for (int b = 0; b < 256; b++) begin
      for (int p = 0; p < 2; p++) begin
        w = tmds_encode(8'(b), p[0]);
        if (first) do_load(w);
        else       do_load(w, 1'b1, 1'b1, 2'b00, prev_b);
        prev_b = 8'(b);
        first = 1'b0;
      end
    end
    do_load(TOK[0], 1'b1, 1'b1, 2'b00, prev_b);

    do_srst();
    repeat (18) do_load(TOK[0]);
    repeat (4) do_load(10'($urandom));
    do_rst();

    // Token stream displaced by 3 bits: offset walks 0..3, then locks.
    t0 = TOK[0];
    for (int i = 0; i < 10; i++) rot[i] = t0[(i + 7) % 10];
    for (int n = 1; n <= 12306; n++) begin
      ck = 1'b1; lk = 1'b0; off = 4'd0;
      if      (n == 4094)  off = 4'd0;
      else if (n == 4095)  off = 4'd1;
      else if (n == 8190)  off = 4'd2;
      else if (n == 12285) off = 4'd3;
      else if (n == 12300) off = 4'd3;
      else if (n == 12301) begin off = 4'd3; lk = 1'b1; end
      else ck = 1'b0;
      do_load(rot, 1'b0, 1'b0, 2'b00, 8'h00, ck, lk, off);
    end

    // Low-transition words can never align into a token: watchdog runs out.
    for (int n = 1; n <= 8192; n++) begin
      case ($urandom_range(0, 3))
        0:       w = 10'h000;
        1:       w = 10'h3FF;
        2:       w = 10'h01F;
        default: w = 10'h3E0;
      endcase
      do_load(w, 1'b0, 1'b0, 2'b00, 8'h00, (n == 8190 || n == 8192), (n == 8190), 4'd3);
    end

    repeat (4) do_idle();
    done = 1'b1;
  end

endmodule
